// File: rtl/dual_ram_arb_pkg.sv
// Shared encodings for the dual-port RAM arbiter: FSM states and requester ids.
package dual_ram_arb_pkg;

  localparam logic [1:0] ST_NORMAL      = 2'd0;
  localparam logic [1:0] ST_LOCKED      = 2'd1;
  localparam logic [1:0] ST_WAIT_UNLOCK = 2'd2;

  localparam logic ID_M0 = 1'b0;
  localparam logic ID_M1 = 1'b1;

endpackage

// File: rtl/dual_ram_arbiter_rr_arb2.sv
// Two-way round-robin grant with a last-grant pointer; mask0 removes m0 from contention.
module rr_arb2
  import dual_ram_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic mask0,
  output logic gnt0,
  output logic gnt1
);

  logic last;
  logic cand0;
  logic cand1;

  assign cand0 = req0 & ~mask0 & ~rst;
  assign cand1 = req1 & ~rst;

  // On contention the requester that is not the pointer wins.
  assign gnt0 = cand0 & (~cand1 | (last == ID_M1));
  assign gnt1 = cand1 & (~cand0 | (last == ID_M0));

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= ID_M1;
    end else if (gnt0) begin
      last <= ID_M0;
    end else if (gnt1) begin
      last <= ID_M1;
    end
  end

endmodule

// File: rtl/dual_ram_arbiter.sv
// Arbitrates m0/m1 onto one RAM write port and one registered read port, with m1 lock.
//   state          | meaning
//   ST_NORMAL      | per-port round-robin
//   ST_LOCKED      | m1 exclusive, lock_cnt bounds the hold
//   ST_WAIT_UNLOCK | lock timed out, round-robin until m1_lock drops
module dual_ram_arbiter
  import dual_ram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int LOCK_MAX   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic                  m1_lock,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  ram_rst_n,
  output logic                  ram_w_en,
  output logic [ADDR_WIDTH-1:0] ram_w_addr,
  output logic [DATA_WIDTH-1:0] ram_w_data,
  output logic                  ram_r_en,
  output logic [ADDR_WIDTH-1:0] ram_r_addr,
  input  logic [DATA_WIDTH-1:0] ram_r_data,
  output logic                  lock_timeout
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_CNT_LAST = CW'(LOCK_MAX - 1);

  logic [1:0]            state;
  logic [CW-1:0]         lock_cnt;
  logic                  locked;
  logic                  wg0, wg1, rg0, rg1;
  logic                  r_pend;
  logic                  rd_id;
  logic                  byp_hit;
  logic [DATA_WIDTH-1:0] byp_data;
  logic [DATA_WIDTH-1:0] rd_data;

  assign locked = (state == ST_LOCKED);

  rr_arb2 u_wr_arb (
    .clk   (clk),
    .rst   (rst),
    .req0  (m0_req & m0_we),
    .req1  (m1_req & m1_we),
    .mask0 (locked),
    .gnt0  (wg0),
    .gnt1  (wg1)
  );

  rr_arb2 u_rd_arb (
    .clk   (clk),
    .rst   (rst),
    .req0  (m0_req & ~m0_we),
    .req1  (m1_req & ~m1_we),
    .mask0 (locked),
    .gnt0  (rg0),
    .gnt1  (rg1)
  );

  assign m0_gnt     = wg0 | rg0;
  assign m1_gnt     = wg1 | rg1;
  assign ram_rst_n  = ~rst;
  assign ram_w_en   = wg0 | wg1;
  assign ram_w_addr = wg1 ? m1_addr  : m0_addr;
  assign ram_w_data = wg1 ? m1_wdata : m0_wdata;
  assign ram_r_en   = rg0 | rg1;
  assign ram_r_addr = rg1 ? m1_addr  : m0_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_NORMAL;
      lock_cnt     <= '0;
      lock_timeout <= 1'b0;
    end else begin
      lock_timeout <= 1'b0;
      case (state)
        ST_NORMAL: begin
          if (m1_gnt && m1_lock) begin
            state    <= ST_LOCKED;
            lock_cnt <= '0;
          end
        end
        ST_LOCKED: begin
          lock_cnt <= lock_cnt + CW'(1);
          if (!m1_lock) begin
            state <= ST_NORMAL;
          end else if (lock_cnt == LOCK_CNT_LAST) begin
            state        <= ST_WAIT_UNLOCK;
            lock_timeout <= 1'b1;
          end
        end
        ST_WAIT_UNLOCK: begin
          if (!m1_lock) state <= ST_NORMAL;
        end
        default: state <= ST_NORMAL;
      endcase
    end
  end

  // The RAM returns old data on a same-address collision, so the write data is replayed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend   <= 1'b0;
      rd_id    <= ID_M0;
      byp_hit  <= 1'b0;
      byp_data <= '0;
    end else begin
      r_pend   <= ram_r_en;
      rd_id    <= rg1 ? ID_M1 : ID_M0;
      byp_hit  <= ram_w_en & ram_r_en & (ram_w_addr == ram_r_addr);
      byp_data <= ram_w_data;
    end
  end

  assign rd_data   = byp_hit ? byp_data : ram_r_data;
  assign m0_rvalid = r_pend & ~rst & (rd_id == ID_M0);
  assign m1_rvalid = r_pend & ~rst & (rd_id == ID_M1);
  assign m0_rdata  = m0_rvalid ? rd_data : '0;
  assign m1_rdata  = m1_rvalid ? rd_data : '0;

endmodule

// File: tb/tb_dual_ram_arbiter.sv
// Directed bench for dual_ram_arbiter with a read-first RAM model; LOCK_MAX is 4.
module tb_dual_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_req, m0_we, m1_req, m1_we, m1_lock;
  logic [11:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_rst_n, ram_w_en, ram_r_en, lock_timeout;
  logic [11:0] ram_w_addr, ram_r_addr;
  logic [31:0] ram_w_data, ram_r_data;
  logic [31:0] mem [0:4095];
  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dual_ram_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .LOCK_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_lock(m1_lock),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt),
    .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .ram_rst_n(ram_rst_n), .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr),
    .ram_w_data(ram_w_data), .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr),
    .ram_r_data(ram_r_data), .lock_timeout(lock_timeout)
  );

  // Read-first RAM: a same-cycle write is not visible to the read.
  always @(posedge clk) begin
    if (!ram_rst_n) begin
      ram_r_data <= '0;
    end else begin
      ram_r_data <= ram_r_en ? mem[ram_r_addr] : '0;
      if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0; m1_lock = 0;
  endtask

  task automatic set0(input logic req, input logic we, input logic [11:0] a, input logic [31:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set1(input logic req, input logic we, input logic [11:0] a, input logic [31:0] d,
                      input logic lk);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; m1_lock = lk;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1; idle();
    tick(); tick();
    // reset forces everything quiet
    set0(1, 1, 12'h010, 32'hAAAA_0000); set1(1, 1, 12'h020, 32'hBBBB_0000, 0); #1;
    check("rst_m0_gnt", m0_gnt, 0);
    check("rst_m1_gnt", m1_gnt, 0);
    check("rst_w_en", ram_w_en, 0);
    check("rst_ram_rst_n", ram_rst_n, 0);
    check("rst_m0_rvalid", m0_rvalid, 0);
    check("rst_lock_timeout", lock_timeout, 0);
    // write contention: m0 first, then m1
    tick(); rst = 0; #1;
    check("c1_m0_gnt", m0_gnt, 1);
    check("c1_m1_gnt", m1_gnt, 0);
    check("c1_w_addr", ram_w_addr, 32'h010);
    check("c1_w_data", ram_w_data, 32'hAAAA_0000);
    check("ram_rst_n", ram_rst_n, 1);
    tick(); #1;
    check("c2_m0_gnt", m0_gnt, 0);
    check("c2_m1_gnt", m1_gnt, 1);
    check("c2_w_addr", ram_w_addr, 32'h020);
    check("c2_w_data", ram_w_data, 32'hBBBB_0000);
    tick(); idle(); set0(1, 0, 12'h010, 0); #1;
    check("rd_m0_gnt", m0_gnt, 1);
    check("rd_r_en", ram_r_en, 1);
    check("rd_r_addr", ram_r_addr, 32'h010);
    check("rd_m0_rvalid_early", m0_rvalid, 0);
    tick(); idle(); #1;
    check("rd_m0_rvalid", m0_rvalid, 1);
    check("rd_m0_rdata", m0_rdata, 32'hAAAA_0000);
    check("rd_m1_rvalid", m1_rvalid, 0);
    check("idle_m0_gnt", m0_gnt, 0);
    check("idle_m1_gnt", m1_gnt, 0);
    // concurrent write+read of the same address takes the bypass
    tick(); set0(1, 1, 12'h005, 32'h1234_5678); set1(1, 0, 12'h005, 0, 0); #1;
    check("byp_m0_gnt", m0_gnt, 1);
    check("byp_m1_gnt", m1_gnt, 1);
    check("byp_w_en", ram_w_en, 1);
    check("byp_r_en", ram_r_en, 1);
    tick(); idle(); #1;
    check("byp_m1_rvalid", m1_rvalid, 1);
    check("byp_m1_rdata", m1_rdata, 32'h1234_5678);
    check("byp_m0_rvalid", m0_rvalid, 0);
    check("byp_m0_rdata", m0_rdata, 0);
    // write then read next cycle comes from the RAM
    tick(); set0(1, 1, 12'h007, 32'hCAFE_F00D); #1;
    check("wr7_m0_gnt", m0_gnt, 1);
    tick(); idle(); set1(1, 0, 12'h007, 0, 0); #1;
    check("rd7_m1_gnt", m1_gnt, 1);
    tick(); idle(); #1;
    check("rd7_m1_rdata", m1_rdata, 32'hCAFE_F00D);
    // lock held for 4 cycles, dropped before timeout
    tick(); set1(1, 0, 12'h020, 0, 1); #1;
    check("lk_entry_m1_gnt", m1_gnt, 1);
    tick(); set0(1, 0, 12'h010, 0); #1;
    check("lk0_m0_gnt", m0_gnt, 0);
    check("lk0_m1_gnt", m1_gnt, 1);
    check("lk0_m1_rdata", m1_rdata, 32'hBBBB_0000);
    tick(); #1;
    check("lk1_m0_gnt", m0_gnt, 0);
    tick(); #1;
    check("lk2_m0_gnt", m0_gnt, 0);
    tick(); m1_lock = 0; m1_req = 0; #1;
    check("lk3_m0_gnt", m0_gnt, 0);
    tick(); #1;
    check("unlk_m0_gnt", m0_gnt, 1);
    check("unlk_timeout", lock_timeout, 0);
    // lock stuck high times out after 4 locked cycles
    tick(); idle(); set1(1, 0, 12'h020, 0, 1); #1;
    check("to_entry_m1_gnt", m1_gnt, 1);
    tick(); set0(1, 0, 12'h010, 0); #1;
    check("to0_m0_gnt", m0_gnt, 0);
    check("to0_timeout", lock_timeout, 0);
    tick(); #1;
    check("to1_m0_gnt", m0_gnt, 0);
    tick(); #1;
    check("to2_m0_gnt", m0_gnt, 0);
    tick(); #1;
    check("to3_m0_gnt", m0_gnt, 0);
    check("to3_timeout", lock_timeout, 0);
    tick(); #1;
    check("w1_timeout", lock_timeout, 1);
    check("w1_m0_gnt", m0_gnt, 1);
    check("w1_m1_gnt", m1_gnt, 0);
    tick(); m0_req = 0; #1;
    check("w2_timeout", lock_timeout, 0);
    check("w2_m1_gnt", m1_gnt, 1);
    tick(); m0_req = 1; #1;
    check("w3_no_relock_m0_gnt", m0_gnt, 1);
    check("w3_m1_gnt", m1_gnt, 0);
    tick(); idle(); #1;
    // reset while an m0 read is in flight
    tick(); set0(1, 0, 12'h005, 0); #1;
    check("rr_m0_gnt", m0_gnt, 1);
    tick(); rst = 1; set0(1, 1, 12'h030, 32'h55); set1(1, 0, 12'h005, 0, 0); #1;
    check("rr_m0_rvalid", m0_rvalid, 0);
    check("rr_m0_rdata", m0_rdata, 0);
    check("rr_m0_gnt", m0_gnt, 0);
    check("rr_m1_gnt", m1_gnt, 0);
    check("rr_w_en", ram_w_en, 0);
    check("rr_r_en", ram_r_en, 0);
    tick(); rst = 0; set0(1, 0, 12'h005, 0); set1(1, 0, 12'h007, 0, 0); #1;
    check("post_rd_m0_gnt", m0_gnt, 1);
    check("post_rd_m1_gnt", m1_gnt, 0);
    check("post_m0_rvalid", m0_rvalid, 0);
    tick(); set0(1, 1, 12'h031, 32'h66); set1(1, 1, 12'h032, 32'h77, 0); #1;
    check("post_wr_m0_gnt", m0_gnt, 1);
    check("post_wr_m1_gnt", m1_gnt, 0);
    check("post_w_addr", ram_w_addr, 32'h031);
    check("post_m0_rvalid2", m0_rvalid, 1);
    check("post_m0_rdata", m0_rdata, 32'h1234_5678);
    tick(); idle(); #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
